fwd_scoreboard: RTL

Parametrised forwarding and load-use hazard unit for the in-order pipeline. It holds its own shadow of in-flight destination registers from EX through the last tracked stage, so the pipeline does not have to feed it back. For each instruction leaving ID it decides, a cycle ahead, which stage each source operand must be forwarded from. It raises a stall when the youngest producer cannot supply data in time, and counts stall cycles.

---
 rtl/fwd_scoreboard_pkg.sv | 15 +
 rtl/fwd_scoreboard_match.sv | 32 +++
 rtl/fwd_scoreboard.sv | 133 +++++++++++++
 3 files changed

// File: rtl/fwd_scoreboard_pkg.sv
// Shared pipeline constants: forward-select encoding, default register width
// and the in-flight slot record used by the scoreboard and the mux decode.
package fwd_scoreboard_pkg;

   localparam int unsigned REG_W_DEF = 6;
   localparam int unsigned FW_RF     = 0;

   typedef struct packed {
      logic                 valid;
      logic [REG_W_DEF-1:0] rd;
      logic                 we;
      logic                 load;
   } slot_t;

endpackage

// File: rtl/fwd_scoreboard_match.sv
// Youngest-match priority search of one source register against the
// forwardable slots; the lowest slot index that produces the register wins.
module fwd_match
   import fwd_scoreboard_pkg::*;
#(
   parameter int unsigned REG_W = REG_W_DEF,
   parameter int unsigned NSLOT = 2,
   parameter int unsigned IDX_W = 1
) (
   input  logic [REG_W-1:0]       src,
   input  logic [NSLOT-1:0]       slot_prod,
   input  logic [NSLOT*REG_W-1:0] slot_rd,
   input  logic [NSLOT-1:0]       slot_load,
   output logic                   hit,
   output logic [IDX_W-1:0]       idx,
   output logic                   is_load
);

   always_comb begin
      hit     = 1'b0;
      idx     = '0;
      is_load = 1'b0;
      for (int unsigned i = 0; i < NSLOT; i++) begin
         if (!hit && slot_prod[i] && (slot_rd[i*REG_W +: REG_W] == src)) begin
            hit     = 1'b1;
            idx     = IDX_W'(i);
            is_load = slot_load[i];
         end
      end
   end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding / load-use hazard unit: shadows in-flight destinations from EX
// to WB, computes next-cycle forward selects and a combinational stall.
module fwd_scoreboard
   import fwd_scoreboard_pkg::*;
#(
   parameter int unsigned REG_W      = REG_W_DEF,
   parameter int unsigned NSRC       = 2,
   parameter int unsigned STAGES     = 3,
   parameter int unsigned LOAD_READY = 2,
   parameter int unsigned SEL_W      = $clog2(STAGES),
   parameter int unsigned CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  id_valid,
   input  logic [NSRC*REG_W-1:0] id_src,
   input  logic [REG_W-1:0]      id_rd,
   input  logic                  id_we,
   input  logic                  id_load,
   input  logic                  flush,
   output logic                  stall,
   output logic [NSRC*SEL_W-1:0] fw_sel,
   output logic                  ex_valid,
   output logic [CNT_W-1:0]      stall_cnt
);

   localparam int unsigned NSLOT = STAGES - 1;

   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] rd;
      logic             we;
      logic             load;
   } slot_rec_t;

   slot_rec_t slot_q [STAGES];
   slot_rec_t slot_d [STAGES];

   logic [NSRC*SEL_W-1:0] fw_sel_q, fw_sel_d, sel_next;
   logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;

   logic [NSLOT-1:0]       prod, ld_v;
   logic [NSLOT*REG_W-1:0] rd_v;

   logic [NSRC-1:0] hit, is_ld, src_stall;
   logic [SEL_W-1:0] idx [NSRC];
   logic accept;

   always_comb begin
      prod = '0;
      ld_v = '0;
      rd_v = '0;
      for (int unsigned i = 0; i < NSLOT; i++) begin
         prod[i]                = slot_q[i].valid && slot_q[i].we && (slot_q[i].rd != '0);
         ld_v[i]                = slot_q[i].load;
         rd_v[i*REG_W +: REG_W] = slot_q[i].rd;
      end
   end

   for (genvar s = 0; s < NSRC; s++) begin : g_src
      fwd_match #(
         .REG_W (REG_W),
         .NSLOT (NSLOT),
         .IDX_W (SEL_W)
      ) u_match (
         .src       (id_src[s*REG_W +: REG_W]),
         .slot_prod (prod),
         .slot_rd   (rd_v),
         .slot_load (ld_v),
         .hit       (hit[s]),
         .idx       (idx[s]),
         .is_load   (is_ld[s])
      );
   end

   // Slot j now sits at j+1 once the consumer reaches EX; a load there is
   // only usable if j+1 has reached LOAD_READY.
   always_comb begin
      src_stall = '0;
      sel_next  = '0;
      for (int unsigned s = 0; s < NSRC; s++) begin
         sel_next[s*SEL_W +: SEL_W] = SEL_W'(FW_RF);
         if (hit[s]) begin
            sel_next[s*SEL_W +: SEL_W] = idx[s] + SEL_W'(1);
            if (is_ld[s] && ((32'(idx[s]) + 32'd1) < LOAD_READY)) begin
               src_stall[s] = 1'b1;
            end
         end
      end
   end

   assign stall  = id_valid && !flush && (|src_stall);
   assign accept = id_valid && !flush && !stall;

   always_comb begin
      slot_d[0] = '0;
      if (accept) begin
         slot_d[0].valid = 1'b1;
         slot_d[0].rd    = id_rd;
         slot_d[0].we    = id_we;
         slot_d[0].load  = id_load;
      end
      for (int unsigned k = 1; k < STAGES; k++) begin
         slot_d[k] = slot_q[k-1];
      end
      fw_sel_d    = accept ? sel_next : '0;
      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            slot_q[k] <= '0;
         end
         fw_sel_q    <= '0;
         stall_cnt_q <= '0;
      end else begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            slot_q[k] <= slot_d[k];
         end
         fw_sel_q    <= fw_sel_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign fw_sel    = fw_sel_q;
   assign ex_valid  = slot_q[0].valid;
   assign stall_cnt = stall_cnt_q;

endmodule
